// File: rtl/mult_div_ctrl_if.sv
// Operation request / result bundle for the iterative multiply-divide unit.
// The master issues start/op/a/b; the slave reports busy, completion strobes and HI/LO.
interface mult_div_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_we, hi, lo, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_we, hi, lo, div0
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide controller producing HI/LO.
// Multiply: 32-cycle shift-add, LSB first, 64-bit accumulator.
// Divide: 32-cycle restoring division, MSB first, 33-bit partial remainder.
// Operands are reduced to magnitudes at accept time and signs are fixed up in FINISH.
// Build option: define MULTDIV_UNSIGNED_EN to make op[1] select unsigned multu/divu;
// otherwise op[1] is ignored and every operation is signed.
module mult_div_ctrl (
  input logic            clk_i,
  input logic            reset_i,
  mult_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;          // mult: {partial, multiplier}; div: low half = quotient
  logic [32:0] rem_q, rem_d;
  logic [31:0] opa_q, opa_d;          // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;    // negate product / quotient
  logic        neg_hi_q, neg_hi_d;    // negate remainder
  logic        div0_pend_q, div0_pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        hilo_we_q, hilo_we_d;
  logic        div0_q, div0_d;

  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        req_div;

`ifdef MULTDIV_UNSIGNED_EN
  assign op_signed = ~bus.op[1];
`else
  logic unused_op1;
  assign unused_op1 = bus.op[1];
  assign op_signed  = 1'b1;
`endif

  assign req_div = bus.op[0];
  assign a_neg   = op_signed & bus.a[31];
  assign b_neg   = op_signed & bus.b[31];
  assign a_mag   = a_neg ? (~bus.a + 32'd1) : bus.a;
  assign b_mag   = b_neg ? (~bus.b + 32'd1) : bus.b;

  // One multiply step: add multiplicand when the current multiplier bit is set, shift right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opa_q : 32'd0)};

  // One restoring-divide step: shift next dividend bit in, trial-subtract the divisor.
  logic [33:0] rem_sh;
  logic [33:0] div_diff;
  logic        div_take;
  assign rem_sh   = {rem_q, acc_q[31]};
  assign div_diff = rem_sh - {2'b00, opa_q};
  assign div_take = ~div_diff[33];

  // Sign correction applied when results are written back.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_hi_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  // Next-state, datapath step and registered strobe generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    opa_d       = opa_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    div0_pend_d = div0_pend_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    hilo_we_d   = 1'b0;
    div0_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d    = req_div;
          cnt_d       = 6'd0;
          rem_d       = 33'd0;
          neg_lo_d    = a_neg ^ b_neg;
          div0_pend_d = req_div & (bus.b == 32'd0);
          if (req_div) begin
            opa_d    = b_mag;
            acc_d    = {32'd0, a_mag};
            neg_hi_d = a_neg;
          end else begin
            opa_d    = a_mag;
            acc_d    = {32'd0, b_mag};
            neg_hi_d = 1'b0;
          end
          // Divide by zero skips the iterations entirely.
          state_d = (req_div && (bus.b == 32'd0)) ? StFinish : StRun;
        end
      end

      StRun: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div_q) begin
          rem_d = div_take ? div_diff[32:0] : rem_sh[32:0];
          acc_d = {32'd0, acc_q[30:0], div_take};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 6'd31) begin
          state_d = StFinish;
        end
      end

      StFinish: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (div0_pend_q) begin
          div0_d = 1'b1;
        end else begin
          hilo_we_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      acc_q       <= 64'd0;
      rem_q       <= 33'd0;
      opa_q       <= 32'd0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      div0_pend_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      done_q      <= 1'b0;
      hilo_we_q   <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      opa_q       <= opa_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      div0_pend_q <= div0_pend_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      hilo_we_q   <= hilo_we_d;
      div0_q      <= div0_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.hilo_we = hilo_we_q;
  assign bus.div0    = div0_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state; reset  input  1  synchronous, active-high.
REQ-002 The block SHALL have these further ports:
- start  input  1  request a new operation.
- op  input  2  00 mult, 01 div, 10 multu, 11 divu.
- a  input  32  multiplicand or dividend.
- b  input  32  multiplier or divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- hilo_we  output  1  HI/LO write strobe; drives HILOWrite.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.
- div0  output  1  one-cycle divide-by-zero pulse.

Function
REQ-003 The block SHALL be an FSM with states IDLE, RUN and FINISH; busy SHALL be 1 exactly when the state is not IDLE.
REQ-004 In IDLE, start=1 at clock edge N SHALL:
- latch op;
- latch |a| and |b| (the raw values for unsigned ops);
- latch result sign flags;
- clear the 6-bit iteration counter;
- enter RUN.
REQ-005 Start SHALL be ignored when the state is not IDLE; a, b and op SHALL be sampled only at the accepting edge.
REQ-006 Multiply SHALL be a shift-add over 32 RUN cycles with a 64-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-007 Divide SHALL be restoring division over 32 RUN cycles, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
REQ-008 RUN SHALL advance to FINISH at edge N+32.
REQ-009 At edge N+33, FINISH SHALL:
- apply sign correction;
- load hi/lo;
- return to IDLE.
done=1 and hilo_we=1 SHALL hold for exactly the following cycle, with hi/lo valid in that cycle.
REQ-010 Signed multiply: the 64-bit product SHALL be negated (two's complement) when exactly one operand was negative.
REQ-011 Signed divide:
- quotient negated when operand signs differ;
- remainder takes the sign of the dividend;
- 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, no flag.
REQ-012 A divide with b=0 SHALL go from IDLE directly to FINISH at edge N. At edge N+1 it SHALL return to IDLE with done=1 and div0=1 for one cycle, hilo_we=0, and hi/lo unchanged.
REQ-013 The cycle in which done=1 SHALL also have busy=0; a start in that cycle SHALL be accepted.
REQ-014 hi and lo SHALL change only on a FINISH edge that writes them, or on reset.
REQ-015 done, hilo_we and div0 SHALL be registered outputs, low in every cycle not listed above.

Reset
REQ-016 Reset SHALL force IDLE and set busy=0, done=0, hilo_we=0, div0=0, hi=0, lo=0, counter=0, accumulators=0.
REQ-017 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never produce done.

Configuration
REQ-018 Macro MULTDIV_UNSIGNED_EN defined:
- op[1]=1 selects unsigned operation (multu/divu);
- operands are used raw;
- no sign correction.
REQ-019 Macro MULTDIV_UNSIGNED_EN undefined:
- op[1] SHALL be ignored;
- every operation is signed;
- the unsigned datapath logic SHALL be absent.

Verification
REQ-020 op=00, a=7, b=0xFFFFFFF9 (-7), start at edge 0 -> done at cycle after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFCF, busy high for 33 cycles.
REQ-021 op=01, a=100, b=7 -> lo=14, hi=2; then op=01, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-022 op=01, a=5, b=0 -> div0=1 and done=1 in the cycle after edge 1, hilo_we=0, hi/lo keep prior values.
REQ-023 op=10, a=b=0xFFFFFFFF:
- with macro -> hi=0xFFFFFFFE, lo=0x00000001;
- without macro -> hi=0x00000000, lo=0x00000001.
REQ-024 Back-to-back: start held high through the done cycle -> second operation accepted in the done cycle; a start pulse mid-RUN is ignored (exactly one done per accepted start).
REQ-025 Reset asserted at edge 10 of a multiply -> next cycle busy=0, hi=lo=0, and no done before the next accepted start.
